// File: rtl/clk_meas_pkg.sv
// Shared types and default parameters for the clk_meas clock monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } meas_state_t;

  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_DEF     = 1000;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous level into clk and flags its rising/falling edges.
// Latency: an input change captured at edge k shows on level/rise/fall after edge k+STAGES-1.
// Backpressure: none; free-running.
//
// Ports: clk, rst (async active-high), d (async input),
//        level (synchronized d), rise/fall (one-cycle combinational edge flags).
module sync_edge_det
  import clk_meas_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              s_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      s_prev <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~s_prev;
  assign fall  = ~level & s_prev;

endmodule

// File: rtl/clk_meas.sv
// Measures high/low/period of an async clock in clk cycles, its phase after a reference, and stuck detection.
// Latency: meas_valid/phase_valid pulse in the cycle after edge k+SYNC_STAGES for an input edge captured at edge k.
// Backpressure: none; results are pulsed and held, never stalled.
//
// Ports: clk, rst (async active-high), sig_in (clock under test), ref_in (phase reference),
//        high_time/low_time/period/sat with meas_valid pulse, phase with phase_valid pulse,
//        stuck and stuck_level (synchronized sig_in level while stuck).
module clk_meas
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             ref_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             sat,
  output logic [CNT_W-1:0] phase,
  output logic             phase_valid,
  output logic             stuck,
  output logic             stuck_level
);

  // The gap counter is sized from TIMEOUT alone so it never wraps before saturating.
  localparam int               GAP_W     = $clog2(TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(TIMEOUT);
  localparam logic [GAP_W:0]   TIMEOUT_V = (GAP_W + 1)'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic s_level, s_rise, s_fall;
  logic r_rise;
  logic ref_level_unused, ref_fall_unused;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sig_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (sig_in),
    .level (s_level),
    .rise  (s_rise),
    .fall  (s_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_ref_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (ref_in),
    .level (ref_level_unused),
    .rise  (r_rise),
    .fall  (ref_fall_unused)
  );

  meas_state_t      state_q, state_d;
  logic [CNT_W-1:0] hi_cnt, lo_cnt, ph_cnt;
  logic             sat_f, armed;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W:0]   gap_inc;
  logic             sig_edge, timeout_hit;
  logic             load_hi, inc_hi, load_lo, inc_lo, take;
  logic [CNT_W-1:0] ph_next;

  assign sig_edge = s_rise | s_fall;
  assign gap_inc  = {1'b0, gap_cnt} + 1'b1;
  // Fire on the cycle the gap count steps to TIMEOUT, so stuck appears exactly
  // TIMEOUT cycles after the cycle in which the last edge's effects became visible.
  // A same-cycle edge wins: the clock is evidently still toggling.
  assign timeout_hit = !sig_edge && (gap_inc >= TIMEOUT_V);
  assign ph_next     = (ph_cnt == CNT_MAX) ? CNT_MAX : ph_cnt + 1'b1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and datapath strobes
  always_comb begin
    state_d = state_q;
    load_hi = 1'b0;
    inc_hi  = 1'b0;
    load_lo = 1'b0;
    inc_lo  = 1'b0;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_rise) begin
          state_d = HIGH;
          load_hi = 1'b1;
        end
      end
      HIGH: begin
        if (s_fall) begin
          state_d = LOW;
          load_lo = 1'b1;
        end else begin
          inc_hi = 1'b1;
        end
      end
      LOW: begin
        if (s_rise) begin
          take    = 1'b1;
          load_hi = 1'b1;
          state_d = HIGH;
        end else begin
          inc_lo = 1'b1;
        end
      end
      STUCK: begin
        if (s_rise) begin
          state_d = HIGH;
          load_hi = 1'b1;
        end else if (s_fall) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != STUCK && timeout_hit) state_d = STUCK;
  end

  // High/low counters and measurement registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_cnt     <= '0;
      lo_cnt     <= '0;
      sat_f      <= 1'b0;
      high_time  <= '0;
      low_time   <= '0;
      period     <= '0;
      sat        <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= take;
      if (take) begin
        high_time <= hi_cnt;
        low_time  <= lo_cnt;
        period    <= {1'b0, hi_cnt} + {1'b0, lo_cnt};
        sat       <= sat_f;
      end
      if (load_hi) begin
        hi_cnt <= CNT_ONE;
        lo_cnt <= '0;
        sat_f  <= 1'b0;
      end else begin
        if (load_lo) lo_cnt <= CNT_ONE;
        if (inc_hi) begin
          if (hi_cnt == CNT_MAX) sat_f  <= 1'b1;
          else                   hi_cnt <= hi_cnt + 1'b1;
        end
        if (inc_lo) begin
          if (lo_cnt == CNT_MAX) sat_f  <= 1'b1;
          else                   lo_cnt <= lo_cnt + 1'b1;
        end
      end
    end
  end

  // Gap counter: cycles since the last sig_in edge, saturating at TIMEOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    gap_cnt <= '0;
    else if (sig_edge)          gap_cnt <= '0;
    else if (gap_cnt != GAP_MAX) gap_cnt <= gap_inc[GAP_W-1:0];
  end

  // Phase: the sig_in rise cycle itself is counted, so rises N cycles apart report N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_cnt      <= '0;
      armed       <= 1'b0;
      phase       <= '0;
      phase_valid <= 1'b0;
    end else begin
      phase_valid <= 1'b0;
      if (r_rise && s_rise) begin
        ph_cnt      <= '0;
        phase       <= '0;
        phase_valid <= 1'b1;
        armed       <= 1'b0;
      end else if (r_rise) begin
        ph_cnt <= '0;
        armed  <= 1'b1;
      end else if (armed) begin
        if (s_rise) begin
          phase       <= ph_next;
          phase_valid <= 1'b1;
          armed       <= 1'b0;
        end else begin
          ph_cnt <= ph_next;
        end
      end
    end
  end

  assign stuck       = (state_q == STUCK);
  assign stuck_level = stuck & s_level;

endmodule

// File: tb/tb_clk_meas.sv
// Randomized and directed bench for clk_meas against an edge-time reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_clk_meas;

  localparam int S   = 2;
  localparam int WA  = 16;
  localparam int TA  = 50;
  localparam int WB  = 4;
  localparam int TB  = 1000;
  localparam int LEN = 700;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sig_in = 1'b0;
  logic ref_in = 1'b0;

  always #5 clk = ~clk;

  logic [WA-1:0] a_high, a_low, a_phase;
  logic [WA:0]   a_period;
  logic          a_mv, a_sat, a_pv, a_stuck, a_lvl;
  logic [WB-1:0] b_high, b_low, b_phase;
  logic [WB:0]   b_period;
  logic          b_mv, b_sat, b_pv, b_stuck, b_lvl;

  clk_meas #(.CNT_W(WA), .SYNC_STAGES(S), .TIMEOUT(TA)) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_in), .ref_in(ref_in),
    .high_time(a_high), .low_time(a_low), .period(a_period), .meas_valid(a_mv),
    .sat(a_sat), .phase(a_phase), .phase_valid(a_pv), .stuck(a_stuck), .stuck_level(a_lvl)
  );

  // Narrow counters with a long timeout so saturation shows without the stuck path.
  clk_meas #(.CNT_W(WB), .SYNC_STAGES(S), .TIMEOUT(TB)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_in), .ref_in(ref_in),
    .high_time(b_high), .low_time(b_low), .period(b_period), .meas_valid(b_mv),
    .sat(b_sat), .phase(b_phase), .phase_valid(b_pv), .stuck(b_stuck), .stuck_level(b_lvl)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cur_j = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %0d, want %0d", tag, cur_j, obs, exp);
    end
  endtask

  // Stimulus waveform, one entry per clk cycle, and expected outputs per DUT.
  bit sig_w[LEN];
  bit ref_w[LEN];
  int len;
  int e_mv[2][LEN], e_h[2][LEN], e_l[2][LEN], e_p[2][LEN], e_sat[2][LEN];
  int e_pv[2][LEN], e_ph[2][LEN], e_st[2][LEN], e_lv[2][LEN];

  task automatic new_wave();
    len = 0;
    for (int j = 0; j < LEN; j++) begin
      sig_w[j] = 1'b0;
      ref_w[j] = 1'b0;
    end
  endtask

  task automatic add_seg(input bit lvl, input int n);
    for (int m = 0; m < n; m++) begin
      if (len < LEN) begin
        sig_w[len] = lvl;
        len++;
      end
    end
  endtask

  task automatic set_ref(input int start, input int width);
    for (int m = start; m < start + width && m < LEN; m++) ref_w[m] = 1'b1;
  endtask

  // Reference model: works on edge times of the stimulus. An input change at
  // index i becomes visible on registered outputs at index i+S+1; the
  // synchronized level at index j is the stimulus at j-S.
  task automatic build_model(input int d, input int w, input int t);
    int  mx, r0, f, last_e, a, k, hh, ll;
    bit  armed, prev_s, prev_r, rise_s, rise_r;
    mx = (1 << w) - 1;
    r0 = -1; f = -1; last_e = -1; a = 0; armed = 1'b0;
    for (int j = 0; j < LEN; j++) begin
      e_mv[d][j] = 0; e_h[d][j] = 0; e_l[d][j] = 0; e_p[d][j] = 0; e_sat[d][j] = 0;
      e_pv[d][j] = 0; e_ph[d][j] = 0; e_st[d][j] = 0; e_lv[d][j] = 0;
    end
    for (int i = 0; i < len; i++) begin
      prev_s = (i == 0) ? 1'b0 : sig_w[i-1];
      prev_r = (i == 0) ? 1'b0 : ref_w[i-1];
      rise_s = sig_w[i] && !prev_s;
      rise_r = ref_w[i] && !prev_r;
      k = i + S + 1;
      if (sig_w[i] != prev_s) begin
        if (last_e >= 0 && i - last_e > t) begin
          for (int m = last_e + S + 1 + t; m < k && m < len; m++) e_st[d][m] = 1;
          r0 = -1; f = -1;
        end
        if (rise_s) begin
          if (r0 >= 0 && f > r0 && k < len) begin
            hh = (f - r0 > mx) ? mx : f - r0;
            ll = (i - f > mx) ? mx : i - f;
            e_mv[d][k]  = 1;
            e_h[d][k]   = hh;
            e_l[d][k]   = ll;
            e_p[d][k]   = hh + ll;
            e_sat[d][k] = ((f - r0 > mx) || (i - f > mx)) ? 1 : 0;
          end
          r0 = i; f = -1;
        end else if (r0 >= 0) begin
          f = i;
        end
        last_e = i;
      end
      if (rise_r && rise_s) begin
        if (k < len) begin e_pv[d][k] = 1; e_ph[d][k] = 0; end
        armed = 1'b0;
      end else if (rise_r) begin
        armed = 1'b1; a = i;
      end else if (rise_s && armed) begin
        if (k < len) begin e_pv[d][k] = 1; e_ph[d][k] = (i - a > mx) ? mx : i - a; end
        armed = 1'b0;
      end
    end
    if (last_e >= 0)
      for (int m = last_e + S + 1 + t; m < len; m++) e_st[d][m] = 1;
    for (int j = 1; j < len; j++) begin
      if (e_mv[d][j] == 0) begin
        e_h[d][j] = e_h[d][j-1]; e_l[d][j] = e_l[d][j-1];
        e_p[d][j] = e_p[d][j-1]; e_sat[d][j] = e_sat[d][j-1];
      end
      if (e_pv[d][j] == 0) e_ph[d][j] = e_ph[d][j-1];
    end
    for (int j = 0; j < len; j++)
      e_lv[d][j] = (e_st[d][j] != 0 && j >= S) ? int'(sig_w[j-S]) : 0;
  endtask

  task automatic check_cycle(input int j);
    cur_j = j;
    chk("A.meas_valid", a_mv, e_mv[0][j]);
    chk("A.high_time", a_high, e_h[0][j]);
    chk("A.low_time", a_low, e_l[0][j]);
    chk("A.period", a_period, e_p[0][j]);
    chk("A.sat", a_sat, e_sat[0][j]);
    chk("A.phase_valid", a_pv, e_pv[0][j]);
    chk("A.phase", a_phase, e_ph[0][j]);
    chk("A.stuck", a_stuck, e_st[0][j]);
    chk("A.stuck_level", a_lvl, e_lv[0][j]);
    chk("B.meas_valid", b_mv, e_mv[1][j]);
    chk("B.high_time", b_high, e_h[1][j]);
    chk("B.low_time", b_low, e_l[1][j]);
    chk("B.period", b_period, e_p[1][j]);
    chk("B.sat", b_sat, e_sat[1][j]);
    chk("B.phase_valid", b_pv, e_pv[1][j]);
    chk("B.phase", b_phase, e_ph[1][j]);
    chk("B.stuck", b_stuck, e_st[1][j]);
    chk("B.stuck_level", b_lvl, e_lv[1][j]);
  endtask

  task automatic check_zero(input int tagn);
    cur_j = tagn;
    chk("rst.A.high_time", a_high, 0);
    chk("rst.A.low_time", a_low, 0);
    chk("rst.A.period", a_period, 0);
    chk("rst.A.meas_valid", a_mv, 0);
    chk("rst.A.sat", a_sat, 0);
    chk("rst.A.phase", a_phase, 0);
    chk("rst.A.phase_valid", a_pv, 0);
    chk("rst.A.stuck", a_stuck, 0);
    chk("rst.A.stuck_level", a_lvl, 0);
    chk("rst.B.high_time", b_high, 0);
    chk("rst.B.period", b_period, 0);
    chk("rst.B.sat", b_sat, 0);
    chk("rst.B.phase", b_phase, 0);
  endtask

  // Reset is raised 3 time units after a rising edge, so the first check
  // (1 unit later) sees only the asynchronous clear.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero(-1);
    sig_in = 1'b0;
    ref_in = 1'b0;
    repeat (3) @(negedge clk);
    check_zero(-2);
    rst = 1'b0;
  endtask

  task automatic run_wave();
    build_model(0, WA, TA);
    build_model(1, WB, TB);
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      check_cycle(j);
      sig_in = sig_w[j];
      ref_in = ref_w[j];
    end
  endtask

  task automatic random_wave();
    bit lvl;
    int j, n;
    new_wave();
    add_seg(1'b0, $urandom_range(1, 8));
    while (len < LEN - 60) begin
      add_seg(1'b1, $urandom_range(1, 20));
      add_seg(1'b0, $urandom_range(1, 20));
    end
    add_seg(1'b1, $urandom_range(1, 6));
    add_seg(1'b0, 10);
    lvl = 1'b0;
    j = 0;
    while (j < len) begin
      n = $urandom_range(1, 15);
      for (int m = 0; m < n && j < len; m++) begin
        ref_w[j] = lvl;
        j++;
      end
      lvl = ~lvl;
    end
  endtask

  initial begin
    do_reset();

    // Duty 3 high / 7 low
    new_wave();
    add_seg(1'b0, 4);
    repeat (8) begin add_seg(1'b1, 3); add_seg(1'b0, 7); end
    add_seg(1'b1, 2);
    add_seg(1'b0, 8);
    run_wave();

    // Phase: sig rises 4 cycles after ref, then both rise together
    do_reset();
    new_wave();
    add_seg(1'b0, 9); add_seg(1'b1, 5); add_seg(1'b0, 5); add_seg(1'b1, 5); add_seg(1'b0, 10);
    set_ref(5, 3);
    set_ref(19, 4);
    run_wave();

    // Stuck high for 60 cycles, fall clears it, then a fresh full period
    do_reset();
    new_wave();
    add_seg(1'b0, 5); add_seg(1'b1, 60); add_seg(1'b0, 5);
    add_seg(1'b1, 4); add_seg(1'b0, 4); add_seg(1'b1, 4); add_seg(1'b0, 10);
    run_wave();

    // Saturation 20/5 on the narrow instance, then 3/3 clears sat
    do_reset();
    new_wave();
    add_seg(1'b0, 3);
    repeat (2) begin add_seg(1'b1, 20); add_seg(1'b0, 5); end
    repeat (3) begin add_seg(1'b1, 3); add_seg(1'b0, 3); end
    add_seg(1'b1, 3);
    add_seg(1'b0, 10);
    run_wave();

    // Reset while HIGH, then measurement restarts from scratch
    do_reset();
    new_wave();
    add_seg(1'b0, 3); add_seg(1'b1, 4); add_seg(1'b0, 4); add_seg(1'b1, 8);
    run_wave();
    do_reset();
    new_wave();
    add_seg(1'b0, 3); add_seg(1'b1, 5); add_seg(1'b0, 6);
    add_seg(1'b1, 5); add_seg(1'b0, 6); add_seg(1'b1, 2); add_seg(1'b0, 8);
    run_wave();

    repeat (6) begin
      do_reset();
      random_wave();
      run_wave();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
